rv32_exec_ctrl: RTL and testbench

- Execute/control slice of the single-cycle RV32IM core: main instruction decoder, integer ALU and branch comparator in one block.
- Decodes the fetched instruction into datapath control signals. Selects ALU operands from register/PC/immediate inputs and computes the ALU result, branch decision and next PC.
- Control signals and the raw ALU result are combinational. Result, branch flag and next PC are also provided registered, with 1-cycle latency, for the writeback/PC stage.

---
 rtl/rv32_exec_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_rv32_exec_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rv32_exec_ctrl.sv
// Execute/control slice of the single-cycle RV32IM core: main decoder, integer ALU
// with M extension, branch comparator and next-PC logic, plus registered result/branch/PC.
module rv32_exec_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iInstr,
  input  logic [31:0] iPC,
  input  logic [31:0] iRead1,
  input  logic [31:0] iRead2,
  input  logic [31:0] iImm,
  output logic        oOrigAULA,
  output logic        oOrigBULA,
  output logic [1:0]  oMem2Reg,
  output logic        oRegWrite,
  output logic        oMemWrite,
  output logic        oMemRead,
  output logic [4:0]  oALUControl,
  output logic [1:0]  oOrigPC,
  output logic        oIllegal,
  output logic [31:0] oALUresult,
  output logic        oZero,
  output logic        oBranch,
  output logic [31:0] oResultQ,
  output logic        oBranchQ,
  output logic [31:0] oNextPCQ
);

  localparam logic [4:0] ALU_AND    = 5'd0;
  localparam logic [4:0] ALU_OR     = 5'd1;
  localparam logic [4:0] ALU_XOR    = 5'd2;
  localparam logic [4:0] ALU_ADD    = 5'd3;
  localparam logic [4:0] ALU_SUB    = 5'd4;
  localparam logic [4:0] ALU_SLT    = 5'd5;
  localparam logic [4:0] ALU_SLTU   = 5'd6;
  localparam logic [4:0] ALU_SLL    = 5'd7;
  localparam logic [4:0] ALU_SRL    = 5'd8;
  localparam logic [4:0] ALU_SRA    = 5'd9;
  localparam logic [4:0] ALU_LUI    = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        unused_instr;

  logic [31:0] alu_a, alu_b;
  logic [4:0]  shamt;
  logic [63:0] mul_a, mul_b, mul_p;
  logic        b_zero, div_ovf;
  logic [31:0] sdiv_b, udiv_b;
  logic [31:0] sdiv_q, sdiv_r, udiv_q, udiv_r;
  logic [31:0] next_pc;
  logic [31:0] jalr_sum;

  logic [31:0] result_d, result_q;
  logic        branch_d, branch_q;
  logic [31:0] next_pc_d, next_pc_q;

  assign opcode       = iInstr[6:0];
  assign funct3       = iInstr[14:12];
  assign funct7       = iInstr[31:25];
  assign unused_instr = ^{iInstr[24:15], iInstr[11:7]};

  // Main decoder: opcode/funct to datapath controls; unknown encodings flag illegal
  always_comb begin
    oOrigAULA   = 1'b0;
    oOrigBULA   = 1'b0;
    oMem2Reg    = 2'b00;
    oRegWrite   = 1'b0;
    oMemWrite   = 1'b0;
    oMemRead    = 1'b0;
    oALUControl = ALU_ADD;
    oOrigPC     = 2'b00;
    oIllegal    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        oOrigBULA   = 1'b1;
        oALUControl = ALU_LUI;
        oRegWrite   = 1'b1;
      end
      OPC_AUIPC: begin
        oOrigAULA = 1'b1;
        oOrigBULA = 1'b1;
        oRegWrite = 1'b1;
      end
      OPC_JAL: begin
        oMem2Reg  = 2'b01;
        oOrigPC   = 2'b10;
        oRegWrite = 1'b1;
      end
      OPC_JALR: begin
        oMem2Reg  = 2'b01;
        oOrigPC   = 2'b11;
        oRegWrite = 1'b1;
        oOrigBULA = 1'b1;
      end
      OPC_BRANCH: begin
        oOrigPC     = 2'b01;
        oALUControl = ALU_SUB;
      end
      OPC_LOAD: begin
        oOrigBULA = 1'b1;
        oMemRead  = 1'b1;
        oMem2Reg  = 2'b10;
        oRegWrite = 1'b1;
      end
      OPC_STORE: begin
        oOrigBULA = 1'b1;
        oMemWrite = 1'b1;
      end
      OPC_OPIMM: begin
        oOrigBULA = 1'b1;
        oRegWrite = 1'b1;
        case (funct3)
          3'b000:  oALUControl = ALU_ADD;
          3'b001:  oALUControl = ALU_SLL;
          3'b010:  oALUControl = ALU_SLT;
          3'b011:  oALUControl = ALU_SLTU;
          3'b100:  oALUControl = ALU_XOR;
          3'b101:  oALUControl = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  oALUControl = ALU_OR;
          3'b111:  oALUControl = ALU_AND;
          default: oALUControl = ALU_ADD;
        endcase
      end
      OPC_OP: begin
        case (funct7)
          7'b0000000: begin
            oRegWrite = 1'b1;
            case (funct3)
              3'b000:  oALUControl = ALU_ADD;
              3'b001:  oALUControl = ALU_SLL;
              3'b010:  oALUControl = ALU_SLT;
              3'b011:  oALUControl = ALU_SLTU;
              3'b100:  oALUControl = ALU_XOR;
              3'b101:  oALUControl = ALU_SRL;
              3'b110:  oALUControl = ALU_OR;
              3'b111:  oALUControl = ALU_AND;
              default: oALUControl = ALU_ADD;
            endcase
          end
          7'b0100000: begin
            case (funct3)
              3'b000: begin
                oALUControl = ALU_SUB;
                oRegWrite   = 1'b1;
              end
              3'b101: begin
                oALUControl = ALU_SRA;
                oRegWrite   = 1'b1;
              end
              default: oIllegal = 1'b1;
            endcase
          end
          7'b0000001: begin
            // M ops are contiguous codes in funct3 order
            oALUControl = ALU_MUL + {2'b00, funct3};
            oRegWrite   = 1'b1;
          end
          default: oIllegal = 1'b1;
        endcase
      end
      default: oIllegal = 1'b1;
    endcase
  end

  assign alu_a  = oOrigAULA ? iPC : iRead1;
  assign alu_b  = oOrigBULA ? iImm : iRead2;
  assign shamt  = alu_b[4:0];

  // One shared 64-bit multiplier; operand extension selects the signedness flavour
  assign mul_a  = {{32{alu_a[31] & ((oALUControl == ALU_MULH) | (oALUControl == ALU_MULHSU))}}, alu_a};
  assign mul_b  = {{32{alu_b[31] & (oALUControl == ALU_MULH)}}, alu_b};
  assign mul_p  = mul_a * mul_b;

  // Divisor forced to 1 on /0 and on MIN/-1 so the divider never sees an undefined case
  assign b_zero  = (alu_b == 32'd0);
  assign div_ovf = (alu_a == 32'h8000_0000) && (alu_b == 32'hFFFF_FFFF);
  assign sdiv_b  = (b_zero || div_ovf) ? 32'd1 : alu_b;
  assign udiv_b  = b_zero ? 32'd1 : alu_b;
  assign sdiv_q  = $signed(alu_a) / $signed(sdiv_b);
  assign sdiv_r  = $signed(alu_a) % $signed(sdiv_b);
  assign udiv_q  = alu_a / udiv_b;
  assign udiv_r  = alu_a % udiv_b;

  // ALU result mux
  always_comb begin
    oALUresult = 32'd0;
    case (oALUControl)
      ALU_AND:    oALUresult = alu_a & alu_b;
      ALU_OR:     oALUresult = alu_a | alu_b;
      ALU_XOR:    oALUresult = alu_a ^ alu_b;
      ALU_ADD:    oALUresult = alu_a + alu_b;
      ALU_SUB:    oALUresult = alu_a - alu_b;
      ALU_SLT:    oALUresult = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:   oALUresult = {31'd0, alu_a < alu_b};
      ALU_SLL:    oALUresult = alu_a << shamt;
      ALU_SRL:    oALUresult = alu_a >> shamt;
      ALU_SRA:    oALUresult = $signed(alu_a) >>> shamt;
      ALU_LUI:    oALUresult = alu_b;
      ALU_MUL:    oALUresult = mul_p[31:0];
      ALU_MULH:   oALUresult = mul_p[63:32];
      ALU_MULHSU: oALUresult = mul_p[63:32];
      ALU_MULHU:  oALUresult = mul_p[63:32];
      ALU_DIV:    oALUresult = b_zero ? 32'hFFFF_FFFF : sdiv_q;
      ALU_DIVU:   oALUresult = b_zero ? 32'hFFFF_FFFF : udiv_q;
      ALU_REM:    oALUresult = b_zero ? alu_a : sdiv_r;
      ALU_REMU:   oALUresult = b_zero ? alu_a : udiv_r;
      default:    oALUresult = 32'd0;
    endcase
  end

  assign oZero = (oALUresult == 32'd0);

  // Branch comparator on raw register values, independent of opcode
  always_comb begin
    oBranch = 1'b0;
    case (funct3)
      3'b000:  oBranch = (iRead1 == iRead2);
      3'b001:  oBranch = (iRead1 != iRead2);
      3'b100:  oBranch = ($signed(iRead1) <  $signed(iRead2));
      3'b101:  oBranch = ($signed(iRead1) >= $signed(iRead2));
      3'b110:  oBranch = (iRead1 <  iRead2);
      3'b111:  oBranch = (iRead1 >= iRead2);
      default: oBranch = 1'b0;
    endcase
  end

  assign jalr_sum = iRead1 + iImm;

  // Next-PC selection
  always_comb begin
    next_pc = iPC + 32'd4;
    case (oOrigPC)
      2'b00:   next_pc = iPC + 32'd4;
      2'b01:   next_pc = oBranch ? (iPC + iImm) : (iPC + 32'd4);
      2'b10:   next_pc = iPC + iImm;
      2'b11:   next_pc = {jalr_sum[31:1], 1'b0};
      default: next_pc = iPC + 32'd4;
    endcase
  end

  // Next-state values for the writeback/PC registers
  always_comb begin
    result_d  = oALUresult;
    branch_d  = oBranch & (oOrigPC == 2'b01);
    next_pc_d = next_pc;
  end

  // Writeback/PC registers with synchronous active-low reset
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      result_q  <= 32'd0;
      branch_q  <= 1'b0;
      next_pc_q <= RESET_PC;
    end else begin
      result_q  <= result_d;
      branch_q  <= branch_d;
      next_pc_q <= next_pc_d;
    end
  end

  assign oResultQ = result_q;
  assign oBranchQ = branch_q;
  assign oNextPCQ = next_pc_q;

endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// Directed vector bench for rv32_exec_ctrl: decode, ALU, branch, next PC and
// registered outputs, plus reset sequences.
module tb_rv32_exec_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        iCLK, iRST;
  logic [31:0] iInstr, iPC, iRead1, iRead2, iImm;
  logic        oOrigAULA, oOrigBULA, oRegWrite, oMemWrite, oMemRead, oIllegal;
  logic [1:0]  oMem2Reg, oOrigPC;
  logic [4:0]  oALUControl;
  logic [31:0] oALUresult, oResultQ, oNextPCQ;
  logic        oZero, oBranch, oBranchQ;

  rv32_exec_ctrl #(.RESET_PC(RST_PC)) dut (
    .iCLK(iCLK), .iRST(iRST), .iInstr(iInstr), .iPC(iPC),
    .iRead1(iRead1), .iRead2(iRead2), .iImm(iImm),
    .oOrigAULA(oOrigAULA), .oOrigBULA(oOrigBULA), .oMem2Reg(oMem2Reg),
    .oRegWrite(oRegWrite), .oMemWrite(oMemWrite), .oMemRead(oMemRead),
    .oALUControl(oALUControl), .oOrigPC(oOrigPC), .oIllegal(oIllegal),
    .oALUresult(oALUresult), .oZero(oZero), .oBranch(oBranch),
    .oResultQ(oResultQ), .oBranchQ(oBranchQ), .oNextPCQ(oNextPCQ)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] instr, pc, r1, r2, imm;
    logic [31:0] res;
    logic        br;
    logic [14:0] ctrl;
    logic [31:0] npc;
    logic        brq;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [14:0] ctl(input logic a, input logic b, input logic [1:0] m2r,
                                      input logic rw, input logic mw, input logic mr,
                                      input logic [4:0] alu, input logic [1:0] opc,
                                      input logic ill);
    return {a, b, m2r, rw, mw, mr, alu, opc, ill};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic add(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                     input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] res,
                     input logic br, input logic [14:0] ctrl, input logic [31:0] npc,
                     input logic brq);
    vec_t v;
    v.instr = instr; v.pc = pc; v.r1 = r1; v.r2 = r2; v.imm = imm;
    v.res = res; v.br = br; v.ctrl = ctrl; v.npc = npc; v.brq = brq;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm);
    iInstr = instr; iPC = pc; iRead1 = r1; iRead2 = r2; iImm = imm;
  endtask

  logic [14:0] act_ctrl;
  assign act_ctrl = {oOrigAULA, oOrigBULA, oMem2Reg, oRegWrite, oMemWrite, oMemRead,
                     oALUControl, oOrigPC, oIllegal};

  initial begin
    // Vector table: instr, pc, rs1, rs2, imm | result, branch, controls, next PC, branchQ
    add(32'h002081B3, 32'h100, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd3,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h4020D1B3, 32'h100, 32'h80000000, 32'd4, 32'd0, 32'hF8000000, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd9,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h0020D1B3, 32'h100, 32'h80000000, 32'd4, 32'd0, 32'h08000000, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd8,2'b00,1'b0), 32'h104, 1'b0);
    add(r_type(7'h20, 3'b000), 32'h100, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd4,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h0020C463, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd8, 32'hFFFFFFFE, 1'b1,
        ctl(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,5'd4,2'b01,1'b0), 32'h108, 1'b1);
    add(32'h0020E463, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd8, 32'hFFFFFFFE, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,5'd4,2'b01,1'b0), 32'h104, 1'b0);
    add(32'h000080E7, 32'h100, 32'h2003, 32'd0, 32'd0, 32'h2003, 1'b0,
        ctl(1'b0,1'b1,2'b01,1'b1,1'b0,1'b0,5'd3,2'b11,1'b0), 32'h2002, 1'b0);
    add(r_type(7'h01, 3'b100), 32'h100, 32'd10, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd15,2'b00,1'b0), 32'h104, 1'b0);
    add(r_type(7'h01, 3'b110), 32'h100, 32'd10, 32'd0, 32'd0, 32'd10, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd17,2'b00,1'b0), 32'h104, 1'b0);
    add(r_type(7'h01, 3'b100), 32'h100, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b1,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd15,2'b00,1'b0), 32'h104, 1'b0);
    add(r_type(7'h01, 3'b110), 32'h100, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b1,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd17,2'b00,1'b0), 32'h104, 1'b0);
    add(r_type(7'h01, 3'b011), 32'h100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd14,2'b00,1'b0), 32'h104, 1'b0);
    add(r_type(7'h01, 3'b001), 32'h100, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFF, 1'b1,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd12,2'b00,1'b0), 32'h104, 1'b0);
    add(r_type(7'h01, 3'b010), 32'h100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd13,2'b00,1'b0), 32'h104, 1'b0);
    add(r_type(7'h01, 3'b000), 32'h100, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd11,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h123450B7, 32'h100, 32'd0, 32'd0, 32'h12345000, 32'h12345000, 1'b1,
        ctl(1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,5'd10,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h00001197, 32'h100, 32'd0, 32'd0, 32'h1000, 32'h1100, 1'b0,
        ctl(1'b1,1'b1,2'b00,1'b1,1'b0,1'b0,5'd3,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h008000EF, 32'h100, 32'd3, 32'd4, 32'd8, 32'd7, 1'b0,
        ctl(1'b0,1'b0,2'b01,1'b1,1'b0,1'b0,5'd3,2'b10,1'b0), 32'h108, 1'b0);
    add(32'h0040A183, 32'h100, 32'h1000, 32'd0, 32'd4, 32'h1004, 1'b0,
        ctl(1'b0,1'b1,2'b10,1'b1,1'b0,1'b1,5'd3,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h0020A423, 32'h100, 32'h1000, 32'd5, 32'd8, 32'h1008, 1'b0,
        ctl(1'b0,1'b1,2'b00,1'b0,1'b1,1'b0,5'd3,2'b00,1'b0), 32'h104, 1'b0);
    add(32'hFFF0A193, 32'h100, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd1, 1'b0,
        ctl(1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,5'd5,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h4040D193, 32'h100, 32'h80000000, 32'd0, 32'h00000404, 32'hF8000000, 1'b0,
        ctl(1'b0,1'b1,2'b00,1'b1,1'b0,1'b0,5'd9,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h00000000, 32'h100, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,5'd3,2'b00,1'b1), 32'h104, 1'b0);
    add(r_type(7'h02, 3'b000), 32'h100, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,5'd3,2'b00,1'b1), 32'h104, 1'b0);
    add(r_type(7'h00, 3'b011), 32'h100, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0,
        ctl(1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,5'd6,2'b00,1'b0), 32'h104, 1'b0);
    add(32'h00208063, 32'hFFFFFFFC, 32'd9, 32'd9, 32'd8, 32'd0, 1'b1,
        ctl(1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,5'd4,2'b01,1'b0), 32'h00000004, 1'b1);

    // Power-on reset
    iRST = 1'b0;
    drive(32'h002081B3, 32'h100, 32'd5, 32'd7, 32'd0);
    @(posedge iCLK); @(posedge iCLK); #1;
    chk("por_resultq", oResultQ, 32'd0);
    chk("por_branchq", {31'd0, oBranchQ}, 32'd0);
    chk("por_nextpcq", oNextPCQ, RST_PC);

    @(negedge iCLK);
    iRST = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge iCLK);
      drive(vecs[i].instr, vecs[i].pc, vecs[i].r1, vecs[i].r2, vecs[i].imm);
      #1;
      chk($sformatf("v%0d_ctrl", i), {17'd0, act_ctrl}, {17'd0, vecs[i].ctrl});
      chk($sformatf("v%0d_alu", i), oALUresult, vecs[i].res);
      chk($sformatf("v%0d_zero", i), {31'd0, oZero}, {31'd0, vecs[i].res == 32'd0});
      chk($sformatf("v%0d_branch", i), {31'd0, oBranch}, {31'd0, vecs[i].br});
      @(posedge iCLK); #1;
      chk($sformatf("v%0d_resultq", i), oResultQ, vecs[i].res);
      chk($sformatf("v%0d_branchq", i), {31'd0, oBranchQ}, {31'd0, vecs[i].brq});
      chk($sformatf("v%0d_nextpcq", i), oNextPCQ, vecs[i].npc);
    end

    // Mid-stream reset on a taken branch discards that cycle's result
    @(negedge iCLK);
    drive(32'h0020C463, 32'h100, 32'hFFFFFFFF, 32'd1, 32'd8);
    #1;
    chk("mid_branch_comb", {31'd0, oBranch}, 32'd1);
    @(posedge iCLK); #1;
    chk("pre_rst_branchq", {31'd0, oBranchQ}, 32'd1);
    chk("pre_rst_nextpcq", oNextPCQ, 32'h108);
    @(negedge iCLK);
    iRST = 1'b0;
    @(posedge iCLK); #1;
    chk("mid_rst_resultq", oResultQ, 32'd0);
    chk("mid_rst_branchq", {31'd0, oBranchQ}, 32'd0);
    chk("mid_rst_nextpcq", oNextPCQ, RST_PC);
    // Release reset with the same inputs: capture resumes the next edge
    @(negedge iCLK);
    iRST = 1'b1;
    @(posedge iCLK); #1;
    chk("post_rst_resultq", oResultQ, 32'hFFFFFFFE);
    chk("post_rst_branchq", {31'd0, oBranchQ}, 32'd1);
    chk("post_rst_nextpcq", oNextPCQ, 32'h108);

    // Back-to-back: registered output tracks each cycle's inputs
    @(negedge iCLK);
    drive(32'h002081B3, 32'h200, 32'd100, 32'd23, 32'd0);
    @(posedge iCLK); #1;
    chk("b2b0_resultq", oResultQ, 32'd123);
    chk("b2b0_nextpcq", oNextPCQ, 32'h204);
    @(negedge iCLK);
    drive(32'h008000EF, 32'h300, 32'd1, 32'd1, 32'hFFFFFFF0);
    @(posedge iCLK); #1;
    chk("b2b1_resultq", oResultQ, 32'd2);
    chk("b2b1_nextpcq", oNextPCQ, 32'h2F0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
